// File: rtl/util_axis_timestamp_insert_pkg.sv
// Shared types and constants for the timestamp-insertion stream stage.
package util_axis_timestamp_insert_pkg;

  localparam int unsigned TS_WIDTH = 64;

  localparam logic [2:0] SPW_1 = 3'd1;
  localparam logic [2:0] SPW_2 = 3'd2;
  localparam logic [2:0] SPW_4 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TS,
    ST_DATA,
    ST_PASS
  } state_t;

  // Samples per channel in one block: 35-bit product, zero-extended.
  function automatic logic [TS_WIDTH-1:0] ts_step(input logic [31:0] len,
                                                  input logic [2:0]  spw);
    logic [34:0] prod;
    prod = 35'(len) * 35'(spw);
    return {{(TS_WIDTH-35){1'b0}}, prod};
  endfunction

endpackage

// File: rtl/util_axis_timestamp_insert_oreg.sv
// Single-stage valid/ready register slice; accepts whenever empty or draining.
module util_axis_timestamp_insert_oreg #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  dma_clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge dma_clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/util_axis_timestamp_insert.sv
// Inserts a running timestamp word ahead of every block of sample words;
// a zero block length turns the stage into a registered pass-through.
module util_axis_timestamp_insert
  import util_axis_timestamp_insert_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  dma_clk,
  input  logic                  reset,
  input  logic [31:0]           timestamp_every,
  input  logic [2:0]            samples_per_word,
  input  logic                  ts_valid,
  output logic                  ts_ready,
  input  logic [TS_WIDTH-1:0]   ts_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_xfer_req,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_xfer_req
);

  state_t                state, state_nxt;
  logic [TS_WIDTH-1:0]   ts_next;
  logic [31:0]           block_len;
  logic [31:0]           word_cnt;
  logic                  push_ts, push_data, load_ts;
  logic                  oreg_ready;
  logic [DATA_WIDTH-1:0] oreg_data;

  // A dropped xfer_req abandons any pending timestamp, but a word already
  // accepted from upstream in the same cycle is still forwarded.
  always_comb begin
    state_nxt    = state;
    push_ts      = 1'b0;
    push_data    = 1'b0;
    load_ts      = 1'b0;
    s_axis_ready = 1'b0;
    ts_ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_axis_xfer_req)
          state_nxt = (timestamp_every == '0) ? ST_PASS : ST_LOAD;
      end
      ST_LOAD: begin
        ts_ready = 1'b1;
        load_ts  = ts_valid;
        if (!s_axis_xfer_req) state_nxt = ST_IDLE;
        else if (ts_valid)    state_nxt = ST_TS;
      end
      ST_TS: begin
        if (!s_axis_xfer_req) begin
          state_nxt = ST_IDLE;
        end else if (oreg_ready) begin
          push_ts   = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        s_axis_ready = oreg_ready;
        if (s_axis_valid && oreg_ready) begin
          push_data = 1'b1;
          if (word_cnt == block_len - 32'd1) state_nxt = ST_TS;
        end
        if (!s_axis_xfer_req) state_nxt = ST_IDLE;
      end
      ST_PASS: begin
        s_axis_ready = oreg_ready;
        push_data    = s_axis_valid && oreg_ready;
        if (!s_axis_xfer_req) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge dma_clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      ts_next         <= '0;
      block_len       <= '0;
      word_cnt        <= '0;
      m_axis_xfer_req <= 1'b0;
    end else begin
      state           <= state_nxt;
      m_axis_xfer_req <= s_axis_xfer_req;
      if (load_ts) ts_next <= ts_data;
      if (push_ts) begin
        block_len <= timestamp_every;
        word_cnt  <= '0;
        ts_next   <= ts_next + ts_step(timestamp_every, samples_per_word);
      end else if (push_data && state == ST_DATA) begin
        word_cnt <= word_cnt + 32'd1;
      end
    end
  end

  assign oreg_data = push_ts ? ts_next : s_axis_data;

  util_axis_timestamp_insert_oreg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_oreg (
    .dma_clk   (dma_clk),
    .reset     (reset),
    .in_valid  (push_ts || push_data),
    .in_ready  (oreg_ready),
    .in_data   (oreg_data),
    .out_valid (m_axis_valid),
    .out_ready (m_axis_ready),
    .out_data  (m_axis_data)
  );

endmodule

// File: tb/tb_util_axis_timestamp_insert.sv
// Directed bench: pass-through, insertion, step scaling, wrap, back-pressure,
// abort and asynchronous reset.
module tb_util_axis_timestamp_insert;

  logic        dma_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] timestamp_every = '0;
  logic [2:0]  samples_per_word = 3'd1;
  logic        ts_valid = 1'b0;
  logic        ts_ready;
  logic [63:0] ts_data = '0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_ready;
  logic [63:0] s_axis_data = '0;
  logic        s_axis_xfer_req = 1'b0;
  logic        m_axis_valid;
  logic        m_axis_ready = 1'b1;
  logic [63:0] m_axis_data;
  logic        m_axis_xfer_req;

  int          checks = 0;
  int          failures = 0;
  int          sink_mode = 0;   // 0: always ready, 1: random, 2: never ready
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  localparam logic [63:0] DBASE = 64'hD000;

  util_axis_timestamp_insert #(
    .DATA_WIDTH (64)
  ) dut (
    .dma_clk          (dma_clk),
    .reset            (reset),
    .timestamp_every  (timestamp_every),
    .samples_per_word (samples_per_word),
    .ts_valid         (ts_valid),
    .ts_ready         (ts_ready),
    .ts_data          (ts_data),
    .s_axis_valid     (s_axis_valid),
    .s_axis_ready     (s_axis_ready),
    .s_axis_data      (s_axis_data),
    .s_axis_xfer_req  (s_axis_xfer_req),
    .m_axis_valid     (m_axis_valid),
    .m_axis_ready     (m_axis_ready),
    .m_axis_data      (m_axis_data),
    .m_axis_xfer_req  (m_axis_xfer_req)
  );

  always #5 dma_clk = ~dma_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge dma_clk);
    #1;
    case (sink_mode)
      0:       m_axis_ready = 1'b1;
      1:       m_axis_ready = 1'($urandom_range(0, 1));
      default: m_axis_ready = 1'b0;
    endcase
  end

  always @(negedge dma_clk) begin
    if (sink_mode == 1 && prev_stall) begin
      check("stall_valid", 64'(m_axis_valid), 64'd1);
      check("stall_data", m_axis_data, prev_data);
    end
    prev_stall = m_axis_valid && !m_axis_ready;
    prev_data  = m_axis_data;
    if (m_axis_valid && m_axis_ready) got_q.push_back(m_axis_data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge dma_clk);
    #1;
  endtask

  task automatic send(input logic [63:0] v);
    int   budget;
    logic acc;
    budget = 0;
    acc = 1'b0;
    s_axis_valid = 1'b1;
    s_axis_data  = v;
    do begin
      @(negedge dma_clk);
      acc = s_axis_ready;
      @(posedge dma_clk);
      #1;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    s_axis_valid = 1'b0;
  endtask

  task automatic wait_count(input int n);
    int budget;
    budget = 0;
    while (got_q.size() < n && budget < 300) begin
      tick(1);
      budget++;
    end
    if (got_q.size() < n) check("wait_timeout", 64'(got_q.size()), 64'(n));
  endtask

  task automatic compare_seq(input string tag);
    wait_count(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic stop_xfer();
    s_axis_xfer_req = 1'b0;
    sink_mode = 0;
    tick(6);
  endtask

  // Blocks of 4 data words each preceded by base + k*step.
  task automatic run_ins(input string tag, input logic [63:0] base, input logic [2:0] spw,
                         input int nwords, input logic [63:0] step, input int mode);
    sink_mode = mode;
    got_q.delete();
    exp_q.delete();
    ts_data = base;
    timestamp_every = 32'd4;
    samples_per_word = spw;
    s_axis_xfer_req = 1'b1;
    for (int i = 0; i < nwords; i++) begin
      if (i % 4 == 0) exp_q.push_back(base + 64'(i / 4) * step);
      exp_q.push_back(DBASE + 64'(i));
    end
    for (int i = 0; i < nwords; i++) send(DBASE + 64'(i));
    compare_seq(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    check("rst_m_valid", 64'(m_axis_valid), 64'd0);
    check("rst_m_data", m_axis_data, 64'd0);
    check("rst_m_xfer", 64'(m_axis_xfer_req), 64'd0);
    check("rst_s_ready", 64'(s_axis_ready), 64'd0);
    check("rst_ts_ready", 64'(ts_ready), 64'd0);
    reset = 1'b0;
    ts_valid = 1'b1;
    tick(2);

    // pass-through
    got_q.delete();
    timestamp_every = '0;
    s_axis_xfer_req = 1'b1;
    tick(1);
    check("pt_xfer_req", 64'(m_axis_xfer_req), 64'd1);
    check("pt_ts_ready", 64'(ts_ready), 64'd0);
    send(64'h1);
    check("pt_lat_valid", 64'(m_axis_valid), 64'd1);
    check("pt_lat_data", m_axis_data, 64'h1);
    for (int i = 2; i <= 12; i++) send(64'(i));
    exp_q.delete();
    for (int i = 1; i <= 12; i++) exp_q.push_back(64'(i));
    compare_seq("pt");
    tick(3);
    check("pt_count", 64'(got_q.size()), 64'd12);
    stop_xfer();
    check("pt_xfer_low", 64'(m_axis_xfer_req), 64'd0);

    run_ins("basic", 64'h100, 3'd1, 12, 64'h4, 0);
    stop_xfer();
    run_ins("step", 64'h10, 3'd2, 12, 64'h8, 0);
    check("step_ts2", got_q[10], 64'h20);
    stop_xfer();
    run_ins("wrap", 64'hFFFF_FFFF_FFFF_FFFE, 3'd1, 8, 64'h4, 0);
    check("wrap_ts1", got_q[5], 64'h2);
    stop_xfer();
    run_ins("bp", 64'h100, 3'd1, 12, 64'h4, 1);
    stop_xfer();

    // abort after two words of a block, then restart with a new base
    run_ins("abort_pre", 64'h300, 3'd1, 2, 64'h4, 0);
    stop_xfer();
    got_q.delete();
    ts_data = 64'h200;
    s_axis_xfer_req = 1'b1;
    wait_count(1);
    if (got_q.size() > 0) check("abort_next", got_q[0], 64'h200);
    send(DBASE);
    stop_xfer();

    // reset asserted while a word sits stalled in the output register
    sink_mode = 2;
    tick(2);
    ts_data = 64'h400;
    s_axis_xfer_req = 1'b1;
    for (int i = 0; i < 50 && !m_axis_valid; i++) @(negedge dma_clk);
    check("rst_mid_held", m_axis_data, 64'h400);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 64'(m_axis_valid), 64'd0);
    check("rst_mid_s_ready", 64'(s_axis_ready), 64'd0);
    check("rst_mid_ts_ready", 64'(ts_ready), 64'd0);
    s_axis_xfer_req = 1'b0;
    sink_mode = 0;
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/util_axis_timestamp_insert.md
# util_axis_timestamp_insert

Inserts 64-bit timestamp words into the DMA-clock sample stream ahead of `util_upack2_timestamp`. A timestamp word is emitted before every `timestamp_every` data words, and each timestamp is advanced by the number of samples per channel carried in the preceding block. The output feeds the unpacker's `s_axis_*` port directly. With `timestamp_every == 0` the block is a registered pass-through.

## Interface
- `DATA_WIDTH`, 64: stream word width. Must equal the timestamp width.
- `dma_clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `timestamp_every` in 32: data words per timestamp block. 0 disables insertion.
- `samples_per_word` in 3: samples per channel per data word. Legal values are 1, 2 and 4.
- `ts_valid` in 1: base-timestamp handshake, valid.
- `ts_ready` out 1: base-timestamp handshake, ready.
- `ts_data` in 64: base timestamp.
- `s_axis_valid` in 1, `s_axis_ready` out 1, `s_axis_data` in 64: raw sample words.
- `s_axis_xfer_req` in 1: transfer active.
- `m_axis_valid` out 1, `m_axis_ready` in 1, `m_axis_data` out 64: merged stream.
- `m_axis_xfer_req` out 1: registered copy of `s_axis_xfer_req`.

## Operation
- States:
  - IDLE: waiting for a transfer.
  - LOAD: waiting for the base timestamp.
  - TS: emitting a timestamp word.
  - DATA: forwarding data words.
  - PASS: pass-through.
- IDLE:
  - `xfer_req` = 1 and `timestamp_every` = 0 → PASS.
  - `xfer_req` = 1 and `timestamp_every` ≠ 0 → LOAD.
- LOAD:
  - `ts_ready` = 1.
  - On `ts_valid & ts_ready`: `ts_next <= ts_data`, then → TS.
- TS:
  - Presents `ts_next` to the output stage.
  - On accept: latch `block_len <= timestamp_every`, clear `word_cnt`, `ts_next <= ts_next + block_len*samples_per_word` (mod 2^64), then → DATA.
- DATA:
  - `s_axis_ready` = output stage can accept.
  - Each accepted word increments `word_cnt`.
  - When `word_cnt` reaches `block_len - 1` on accept → TS.
- PASS: `s_axis_ready` = output stage can accept. No timestamps are inserted.
- `xfer_req` falling in any state:
  - Finish the word already held in the output register.
  - Discard the pending timestamp.
  - → IDLE.
  - A partial block is legal. `ts_next` is not adjusted.
- `timestamp_every` is sampled only in IDLE and TS. Changing it mid-block has no effect until the next TS.
- `s_axis_ready` = 0 in IDLE, LOAD and TS.
- `ts_ready` = 0 outside LOAD.
- Arithmetic:
  - The increment is `block_len * samples_per_word`, 35 bits, zero-extended to 64 bits.
  - Timestamp addition wraps at 2^64.
  - `word_cnt` is 32 bits.

## Timing
- Reset values:
  - State = IDLE.
  - `m_axis_valid` = 0, `m_axis_data` = 0, `m_axis_xfer_req` = 0.
  - `s_axis_ready` = 0, `ts_ready` = 0.
  - `ts_next` = 0.
- Output stage:
  - One register slice.
  - Can accept when `!m_axis_valid || m_axis_ready`, so it sustains one word per cycle.
  - Input-to-output latency is 1 cycle.
- `m_axis_valid` must hold, with `m_axis_data` stable, until `m_axis_ready` is high.
- Overhead per block:
  - TS costs exactly 1 cycle with no bubble when `m_axis_ready` is held high.
  - LOAD costs 1 cycle when `ts_valid` is already high.
- `s_axis_ready` is combinational from state and the output-register status. It never depends on `s_axis_valid`.
- Reset asserted mid-transfer: all state is cleared asynchronously and any in-flight word is dropped.

## Structure
- Package `util_axis_timestamp_insert_pkg` holds:
  - the state enum;
  - `TS_WIDTH = 64`;
  - the legal `samples_per_word` constants.
- Sub-module `util_axis_timestamp_insert_oreg` is the single-stage valid/ready register slice, with its own `dma_clk` and `reset`.
- The top level contains the FSM, counters and timestamp adder.

## Test plan
- Pass-through:
  - Stimulus: `timestamp_every` = 0, 12 words 0x1..0xC.
  - Required: the same 12 words out, no insertions, 1-cycle latency.
- Basic insertion:
  - Stimulus: `timestamp_every` = 4, `samples_per_word` = 1, base 0x100, 12 data words.
  - Required: output is `0x100`, d0–d3, `0x104`, d4–d7, `0x108`, d8–d11.
- Step scaling:
  - Stimulus: `timestamp_every` = 4, `samples_per_word` = 2, base 0x10.
  - Required: timestamps 0x10, 0x18, 0x20.
- Wrap-around:
  - Stimulus: base 0xFFFF_FFFF_FFFF_FFFE, `timestamp_every` = 4, `samples_per_word` = 1.
  - Required: second timestamp is 0x2.
- Back-pressure:
  - Stimulus: `m_axis_ready` toggling on a random 50% pattern.
  - Required: sequence identical to the basic-insertion case, and `m_axis_data` stable while stalled.
- Abort and reset:
  - Stimulus: `xfer_req` dropped after 2 words of a block, then raised again with base 0x200.
  - Required: the next output is `0x200`.
  - Stimulus: `reset` pulsed mid-block.
  - Required: `m_axis_valid` = 0 immediately.
